// File: rtl/reg_file_wb.sv
// Four-entry register file with two combinational read ports, one synchronous write port
// and a free-running scanner that cycles through the registers for debug display.
module reg_file_wb #(
   parameter int DATA_WIDTH = 8,
   parameter int ZERO_REG   = 1,
   parameter int SCAN_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWrite,
   input  logic [1:0]            WriteAddr,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [1:0]            ReadAddr1,
   input  logic [1:0]            ReadAddr2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   output logic [1:0]            disp_addr,
   output logic [DATA_WIDTH-1:0] disp_data,
   output logic                  disp_tick
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [DATA_WIDTH-1:0] regs_q [4];
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            disp_addr_q, disp_addr_d;
   logic                  disp_tick_q, disp_tick_d;
   logic                  wr_en;
   logic                  scan_step;

   // Writes to the hard-wired zero register are dropped here so the bypass ignores them too.
   assign wr_en = RegWrite && !((ZERO_REG != 0) && (WriteAddr == 2'd0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[WriteAddr] <= WriteData;
      end
   end

   always_comb begin
      ReadData1 = regs_q[ReadAddr1];
      if (wr_en && (WriteAddr == ReadAddr1)) begin
         ReadData1 = WriteData;
      end
      if ((ZERO_REG != 0) && (ReadAddr1 == 2'd0)) begin
         ReadData1 = '0;
      end

      ReadData2 = regs_q[ReadAddr2];
      if (wr_en && (WriteAddr == ReadAddr2)) begin
         ReadData2 = WriteData;
      end
      if ((ZERO_REG != 0) && (ReadAddr2 == 2'd0)) begin
         ReadData2 = '0;
      end
   end

   always_comb begin
      scan_step   = (cnt_q == CNT_LAST);
      cnt_d       = scan_step ? '0 : cnt_q + CNT_W'(1);
      disp_addr_d = scan_step ? disp_addr_q + 2'd1 : disp_addr_q;
      disp_tick_d = scan_step;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         disp_addr_q <= 2'd0;
         disp_tick_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         disp_addr_q <= disp_addr_d;
         disp_tick_q <= disp_tick_d;
      end
   end

   assign disp_addr = disp_addr_q;
   assign disp_tick = disp_tick_q;
   assign disp_data = ((ZERO_REG != 0) && (disp_addr_q == 2'd0)) ? '0 : regs_q[disp_addr_q];

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized, self-checking bench for reg_file_wb: one instance with a zero register and
// SCAN_DIV=4, one with an ordinary r0 and SCAN_DIV=1, both fed the same stimulus.
module tb_reg_file_wb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RegWrite = 1'b0;
   logic [1:0] WriteAddr = 2'd0;
   logic [7:0] WriteData = 8'd0;
   logic [1:0] ReadAddr1 = 2'd0;
   logic [1:0] ReadAddr2 = 2'd0;

   logic [7:0] rd1_a, rd2_a, dd_a, rd1_b, rd2_b, dd_b;
   logic [1:0] da_a, da_b;
   logic       dt_a, dt_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_file_wb #(.DATA_WIDTH(8), .ZERO_REG(1), .SCAN_DIV(4)) dut_a (
      .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
      .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .ReadData1(rd1_a), .ReadData2(rd2_a),
      .disp_addr(da_a), .disp_data(dd_a), .disp_tick(dt_a));

   reg_file_wb #(.DATA_WIDTH(8), .ZERO_REG(0), .SCAN_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
      .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .ReadData1(rd1_b), .ReadData2(rd2_b),
      .disp_addr(da_b), .disp_data(dd_b), .disp_tick(dt_b));

   // Reference model: register contents and number of clock edges since reset release.
   logic [7:0] mem_a [4];
   logic [7:0] mem_b [4];
   int         cyc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            mem_a[i] <= 8'd0;
            mem_b[i] <= 8'd0;
         end
         cyc <= 0;
      end else begin
         if (RegWrite && WriteAddr != 2'd0) mem_a[WriteAddr] <= WriteData;
         if (RegWrite) mem_b[WriteAddr] <= WriteData;
         cyc <= cyc + 1;
      end
   end

   function automatic logic [7:0] exp_rd(input bit zr, input logic [1:0] a);
      if (zr && a == 2'd0) return 8'd0;
      if (RegWrite && WriteAddr == a) return WriteData;
      return zr ? mem_a[a] : mem_b[a];
   endfunction

   function automatic logic [7:0] exp_disp(input bit zr, input logic [1:0] a);
      if (zr && a == 2'd0) return 8'd0;
      return zr ? mem_a[a] : mem_b[a];
   endfunction

   function automatic logic [1:0] exp_daddr(input int sd);
      return 2'((cyc / sd) % 4);
   endfunction

   function automatic logic exp_tick(input int sd);
      return (cyc >= 1) && (cyc % sd == 0);
   endfunction

   task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic [1:0] ra1, input logic [1:0] ra2);
      @(negedge clk);
      RegWrite  = we;
      WriteAddr = wa;
      WriteData = wd;
      ReadAddr1 = ra1;
      ReadAddr2 = ra2;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      RegWrite = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (da_a !== 2'd0 || dt_a !== 1'b0 || da_b !== 2'd0 || dt_b !== 1'b0) begin
         bad++;
         $display("FAIL reset_disp got addr=%0d/%0d tick=%0d/%0d exp 0/0 0/0", da_a, da_b, dt_a, dt_b);
      end
      for (int a = 0; a < 4; a++) begin
         ReadAddr1 = 2'(a);
         ReadAddr2 = 2'(3 - a);
         #1;
         total++;
         if (rd1_a !== 8'd0 || rd2_a !== 8'd0 || rd1_b !== 8'd0 || rd2_b !== 8'd0) begin
            bad++;
            $display("FAIL reset_read a=%0d got %h %h %h %h exp 00", a, rd1_a, rd2_a, rd1_b, rd2_b);
         end
      end
      $display("reset checked");
   endtask

   task automatic test_write_read();
      drive(1'b1, 2'd2, 8'hA5, 2'd0, 2'd0);
      drive(1'b1, 2'd3, 8'h3C, 2'd0, 2'd0);
      drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd3);
      total++;
      if (rd1_a !== 8'hA5 || rd2_a !== 8'h3C || rd1_b !== 8'hA5 || rd2_b !== 8'h3C) begin
         bad++;
         $display("FAIL write_read got %h %h %h %h exp a5 3c", rd1_a, rd2_a, rd1_b, rd2_b);
      end
      drive(1'b0, 2'd2, 8'hFF, 2'd2, 2'd2);
      drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd2);
      total++;
      if (rd1_a !== 8'hA5 || rd2_b !== 8'hA5) begin
         bad++;
         $display("FAIL no_write got %h %h exp a5", rd1_a, rd2_b);
      end
      $display("write/read: r2=%h r3=%h", rd1_a, rd2_a);
   endtask

   task automatic test_zero_reg();
      drive(1'b1, 2'd0, 8'h77, 2'd1, 2'd1);
      drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
      total++;
      if (rd1_a !== 8'h00 || rd1_b !== 8'h77) begin
         bad++;
         $display("FAIL zero_reg got zr=%h nz=%h exp 00 77", rd1_a, rd1_b);
      end
      // Bypass must not leak a discarded r0 write on the zero-register build.
      drive(1'b1, 2'd0, 8'h55, 2'd0, 2'd0);
      total++;
      if (rd1_a !== 8'h00 || rd2_b !== 8'h55) begin
         bad++;
         $display("FAIL zero_bypass got zr=%h nz=%h exp 00 55", rd1_a, rd2_b);
      end
      $display("zero reg: zr=%h nz=%h", rd1_a, rd2_b);
   endtask

   task automatic test_bypass();
      drive(1'b1, 2'd1, 8'h11, 2'd0, 2'd0);
      drive(1'b1, 2'd1, 8'h22, 2'd1, 2'd3);
      total++;
      if (rd1_a !== 8'h22 || rd1_b !== 8'h22 || rd2_a !== 8'h3C) begin
         bad++;
         $display("FAIL bypass_pre got %h %h %h exp 22 22 3c", rd1_a, rd1_b, rd2_a);
      end
      drive(1'b0, 2'd1, 8'h99, 2'd1, 2'd1);
      total++;
      if (rd1_a !== 8'h22 || rd2_b !== 8'h22) begin
         bad++;
         $display("FAIL bypass_post got %h %h exp 22", rd1_a, rd2_b);
      end
      $display("bypass: r1=%h", rd1_a);
   endtask

   task automatic test_scanner();
      do_reset();
      drive(1'b1, 2'd1, 8'h10, 2'd0, 2'd0);
      drive(1'b1, 2'd2, 8'h20, 2'd0, 2'd0);
      drive(1'b1, 2'd3, 8'h30, 2'd0, 2'd0);
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
         total++;
         if (da_a !== exp_daddr(4) || dt_a !== exp_tick(4) || dd_a !== exp_disp(1'b1, exp_daddr(4))) begin
            bad++;
            $display("FAIL scan_a cyc=%0d got addr=%0d tick=%0d data=%h exp addr=%0d tick=%0d data=%h",
                     cyc, da_a, dt_a, dd_a, exp_daddr(4), exp_tick(4), exp_disp(1'b1, exp_daddr(4)));
         end
         total++;
         if (da_b !== exp_daddr(1) || dt_b !== exp_tick(1) || dd_b !== exp_disp(1'b0, exp_daddr(1))) begin
            bad++;
            $display("FAIL scan_b cyc=%0d got addr=%0d tick=%0d data=%h exp addr=%0d tick=%0d data=%h",
                     cyc, da_b, dt_b, dd_b, exp_daddr(1), exp_tick(1), exp_disp(1'b0, exp_daddr(1)));
         end
         $display("scan cyc=%0d addr=%0d data=%h tick=%0d", cyc, da_a, dd_a, dt_a);
      end
   endtask

   task automatic test_random();
      logic we;
      logic [1:0] wa, r1, r2;
      logic [7:0] wd;
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         wa = 2'($urandom_range(0, 3));
         wd = 8'($urandom);
         r1 = (i % 3 == 0) ? wa : 2'($urandom_range(0, 3));
         r2 = 2'($urandom_range(0, 3));
         drive(we, wa, wd, r1, r2);
         total++;
         if (rd1_a !== exp_rd(1'b1, r1) || rd2_a !== exp_rd(1'b1, r2) ||
             rd1_b !== exp_rd(1'b0, r1) || rd2_b !== exp_rd(1'b0, r2)) begin
            bad++;
            $display("FAIL rand_read we=%0d wa=%0d wd=%h r1=%0d r2=%0d got %h %h %h %h exp %h %h %h %h",
                     we, wa, wd, r1, r2, rd1_a, rd2_a, rd1_b, rd2_b, exp_rd(1'b1, r1),
                     exp_rd(1'b1, r2), exp_rd(1'b0, r1), exp_rd(1'b0, r2));
         end
         total++;
         if (da_a !== exp_daddr(4) || dt_a !== exp_tick(4) || dd_a !== exp_disp(1'b1, exp_daddr(4)) ||
             da_b !== exp_daddr(1) || dt_b !== exp_tick(1) || dd_b !== exp_disp(1'b0, exp_daddr(1))) begin
            bad++;
            $display("FAIL rand_disp cyc=%0d got %0d %0d %h / %0d %0d %h", cyc, da_a, dt_a, dd_a,
                     da_b, dt_b, dd_b);
         end
         $display("rand %0d we=%0d wa=%0d wd=%h rd1=%h rd2=%h", i, we, wa, wd, rd1_a, rd2_a);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 2'd3, 8'h5A, 2'd3, 2'd2);
      drive(1'b1, 2'd2, 8'h6B, 2'd3, 2'd3);
      drive(1'b1, 2'd3, 8'h99, 2'd3, 2'd2);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (da_a !== 2'd0 || dt_a !== 1'b0 || da_b !== 2'd0 || dt_b !== 1'b0 ||
          rd2_a !== 8'h00 || rd2_b !== 8'h00) begin
         bad++;
         $display("FAIL async_rst got addr=%0d/%0d tick=%0d/%0d r2=%h/%h exp 0", da_a, da_b,
                  dt_a, dt_b, rd2_a, rd2_b);
      end
      @(negedge clk);
      RegWrite = 1'b0;
      #1;
      total++;
      if (rd1_a !== 8'h00 || rd1_b !== 8'h00) begin
         bad++;
         $display("FAIL async_rst_r3 got %h %h exp 00", rd1_a, rd1_b);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (rd1_a !== 8'h00 || rd1_b !== 8'h00 || da_a !== 2'd0) begin
         bad++;
         $display("FAIL async_rst_after got %h %h addr=%0d exp 00 00 0", rd1_a, rd1_b, da_a);
      end
      $display("async reset: r3=%h disp_addr=%0d", rd1_a, da_a);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_reg();
      test_bypass();
      test_scanner();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
